// File: rtl/hex_display_pkg.sv
// hex_display_pkg: segment codes, scan FSM states and counter width helper
package hex_display_pkg;
  localparam logic [0:6] SEG_OFF = 7'b1111111;
  localparam logic [0:6] SEG_0 = 7'b0000001;
  localparam logic [0:6] SEG_1 = 7'b1001111;
  localparam logic [0:6] SEG_2 = 7'b0010010;
  localparam logic [0:6] SEG_3 = 7'b0000110;
  localparam logic [0:6] SEG_4 = 7'b1001100;
  localparam logic [0:6] SEG_5 = 7'b0100100;
  localparam logic [0:6] SEG_6 = 7'b0100000;
  localparam logic [0:6] SEG_7 = 7'b0001101;
  localparam logic [0:6] SEG_8 = 7'b0000000;
  localparam logic [0:6] SEG_9 = 7'b0000100;
  localparam logic [0:6] SEG_A = 7'b0001000;
  localparam logic [0:6] SEG_B = 7'b1100000;
  localparam logic [0:6] SEG_C = 7'b0110001;
  localparam logic [0:6] SEG_D = 7'b1000010;
  localparam logic [0:6] SEG_E = 7'b0110000;
  localparam logic [0:6] SEG_F = 7'b0111000;
  typedef enum logic {GUARD, DRIVE} state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hex_display_scan_lut.sv
// hex_seg_lut: hex nibble to active-low a..g segment code
module hex_seg_lut
  import hex_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [0:6] seg
);
  always_comb begin
    unique case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end
endmodule

// File: rtl/hex_display_scan.sv
// hex_display_scan: multiplexed seven-segment scanner with guard cycles; HEX_DISPLAY_LZ_EN adds leading-zero suppression
module hex_display_scan
  import hex_display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     dp,
  output logic [0:6]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an
);
  localparam int IW = cnt_w(DIGITS);
  localparam int PW = cnt_w(SCAN_DIV);
  state_t              state;
  logic [IW-1:0]       idx;
  logic [PW-1:0]       pcnt;
  logic [4*DIGITS-1:0] shadow;
  logic [3:0]          nib;
  logic [0:6]          lut_seg;
  logic [DIGITS-1:0]   lz;
  logic                show;
  assign nib = shadow[4*idx +: 4];
  hex_seg_lut u_lut (.nib(nib), .seg(lut_seg));
`ifdef HEX_DISPLAY_LZ_EN
  logic zrun;
  // a digit is a leading zero when it and every digit above it are zero
  always_comb begin
    lz = '0;
    zrun = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zrun = zrun & (shadow[4*i +: 4] == 4'h0);
      lz[i] = zrun;
    end
  end
`else
  assign lz = '0;
`endif
  assign show = (state == DRIVE) && !(blank_mask[idx] || lz[idx]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= GUARD;
      idx    <= '0;
      pcnt   <= '0;
      shadow <= '0;
      seg    <= SEG_OFF;
      an     <= '1;
      dp_out <= 1'b1;
    end else begin
      if (load) shadow <= value;
      seg    <= show ? lut_seg : SEG_OFF;
      an     <= show ? ~(DIGITS'(1) << idx) : '1;
      dp_out <= show ? ~dp[idx] : 1'b1;
      if (state == GUARD) begin
        state <= DRIVE;
        pcnt  <= '0;
      end else if (pcnt == PW'(SCAN_DIV - 1)) begin
        pcnt  <= '0;
        idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        state <= GUARD;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hex_display_scan.sv
// tb_hex_display_scan: directed checks of reset, scan order, blanking, live load and reset mid-scan
module tb_hex_display_scan;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  dp = '0;
  logic [0:6]  seg;
  logic        dp_out;
  logic [3:0]  an;
  int checks = 0;
  int errors = 0;

  hex_display_scan #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .blank_mask(blank_mask), .dp(dp), .seg(seg), .dp_out(dp_out), .an(an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_off(input string tag);
    check({tag, "_an"}, an, 4'hf);
    check({tag, "_seg"}, seg, 7'b1111111);
    check({tag, "_dp"}, dp_out, 1'b1);
  endtask

  // waits (bounded) for the first cycle of a visible digit-0 slot
  task automatic sync0();
    logic [3:0] prev = an;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (an == 4'he && prev == 4'hf) return;
      prev = an;
    end
    checks++; errors++;
    $display("FAIL sync0: digit 0 slot not found within 60 cycles");
  endtask

  task automatic wait_an(input logic [3:0] target);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (an == target) return;
    end
    checks++; errors++;
    $display("FAIL wait_an: an never reached %b", target);
  endtask

  // entered on the first cycle of digit d's slot; covers the slot and its guard
  task automatic check_slot(input int d, input logic [6:0] s, input logic dpv, input logic dark);
    logic [3:0] ea = dark ? 4'hf : ~(4'b0001 << d);
    logic [6:0] es = dark ? 7'b1111111 : s;
    logic       ed = dark ? 1'b1 : dpv;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d%0d_c%0d_an", d, k), an, ea);
      check($sformatf("d%0d_c%0d_seg", d, k), seg, es);
      check($sformatf("d%0d_c%0d_dp", d, k), dp_out, ed);
      @(negedge clk);
    end
    check($sformatf("d%0d_guard_an", d), an, 4'hf);
    check($sformatf("d%0d_guard_seg", d), seg, 7'b1111111);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  always @(negedge clk) if (rst_n) check("an_onehot", $countones(~an) <= 1, 1'b1);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic lz_dark;
`ifdef HEX_DISPLAY_LZ_EN
    lz_dark = 1'b1;
`else
    lz_dark = 1'b0;
`endif
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_off($sformatf("rst%0d", c));
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_off("edge1");
    @(negedge clk);
    check("edge2_an", an, 4'he);
    check("edge2_seg", seg, 7'b0000001);

    do_load(16'h12AF);
    sync0();
    check_slot(0, 7'b0111000, 1'b1, 1'b0);
    check_slot(1, 7'b0001000, 1'b1, 1'b0);
    check_slot(2, 7'b0010010, 1'b1, 1'b0);
    check_slot(3, 7'b1001111, 1'b1, 1'b0);
    check("wrap_an", an, 4'he);

    blank_mask = 4'b0100;
    dp = 4'b0001;
    sync0();
    check_slot(0, 7'b0111000, 1'b0, 1'b0);
    check_slot(1, 7'b0001000, 1'b1, 1'b0);
    check_slot(2, 7'b0010010, 1'b1, 1'b1);
    check_slot(3, 7'b1001111, 1'b1, 1'b0);
    blank_mask = '0;
    dp = '0;

    do_load(16'h0000);
    sync0();
    check("mid_before_seg", seg, 7'b0000001);
    do_load(16'h0008);
    check("mid_loadedge_seg", seg, 7'b0000001);
    @(negedge clk);
    check("mid_after_seg", seg, 7'b0000000);
    check("mid_after_an", an, 4'he);
    @(negedge clk);
    check("mid_last_seg", seg, 7'b0000000);
    check("mid_last_an", an, 4'he);
    @(negedge clk);
    check_off("mid_guard");

    do_load(16'h0005);
    sync0();
    check_slot(0, 7'b0100100, 1'b1, 1'b0);
    check_slot(1, 7'b0000001, 1'b1, lz_dark);
    check_slot(2, 7'b0000001, 1'b1, lz_dark);
    check_slot(3, 7'b0000001, 1'b1, lz_dark);
    do_load(16'h0000);
    sync0();
    check_slot(0, 7'b0000001, 1'b1, 1'b0);
    check_slot(1, 7'b0000001, 1'b1, lz_dark);

    do_load(16'h3C7B);
    wait_an(4'b1011);
    check("pre_rst_seg", seg, 7'b0110001);
    #2 rst_n = 1'b0;
    #1 check_off("async_rst");
    @(negedge clk);
    @(negedge clk);
    check_off("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_off("rel_edge1");
    @(negedge clk);
    check("rel_edge2_an", an, 4'he);
    check("rel_edge2_seg", seg, 7'b0000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hex_display_scan.md
# hex_display_scan

Time-multiplexed driver for a bank of common-anode seven-segment digits. It latches a packed hexadecimal value and scans the digits one at a time through a shared segment bus. Each digit is translated with the team's standard hex-to-segment table. A one-cycle all-off guard between digits suppresses ghosting. The block sits between datapath registers and the board's display pins.

## Interface
- `DIGITS`, default 4: number of digits, legal range 1..8.
- `SCAN_DIV`, default 50000: clock cycles each digit is driven, must be ≥1.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `value` input 4*DIGITS: packed nibbles; nibble i (`value[4i+3:4i]`) is digit i, and digit 0 is the rightmost.
- `load` input 1: when high at a rising edge, `value` is copied into the shadow register.
- `blank_mask` input DIGITS: bit i high forces digit i dark.
- `dp` input DIGITS: bit i high lights the decimal point of digit i.
- `seg` output [0:6]: segments a..g, active-low (0 = lit).
- `dp_out` output 1: decimal point, active-low.
- `an` output DIGITS: digit enables, active-low, at most one low at any time.

## Operation
- Shadow register `shadow` (4*DIGITS bits) holds what is displayed. It changes only on `load`.
- FSM states:
  - GUARD: one cycle; next state is DRIVE.
  - DRIVE: the prescaler `pcnt` counts 0..SCAN_DIV-1. At `pcnt==SCAN_DIV-1` it clears `pcnt`, advances `idx` (DIGITS-1 wraps to 0) and goes to GUARD.
  - `pcnt` is held at 0 in GUARD.
- Digit period = SCAN_DIV+1 cycles; full frame = DIGITS*(SCAN_DIV+1) cycles.
- Output registers `seg`, `an`, `dp_out` are loaded every cycle from the current state, `idx` and `shadow`:
  - GUARD: all off (`an` all ones, `seg`=1111111, `dp_out`=1).
  - DRIVE, digit not dark: `an[idx]`=0, `seg`=LUT(shadow nibble idx), `dp_out`=~dp[idx].
  - DRIVE, digit dark: same as GUARD (`an` off, `seg` off, `dp_out`=1).
- LUT, values 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001101, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000. All 16 codes are defined; there is no default case.
- Widths:
  - `idx` is max(1, $clog2(DIGITS)) bits. With DIGITS=1, `idx` stays 0.
  - `pcnt` is max(1, $clog2(SCAN_DIV)) bits. With SCAN_DIV=1, DRIVE lasts exactly one cycle.
- `load` during any state updates `shadow` without disturbing `idx`, `pcnt` or the FSM state.
- `blank_mask` and `dp` are sampled live; they are not shadowed.

## Timing
- Reset (async assert): FSM=GUARD, `idx`=0, `pcnt`=0, `shadow`=0, `an`=all ones, `seg`=1111111, `dp_out`=1. Outputs go off immediately on assertion, without waiting for a clock.
- After deassertion:
  - Edge 1: FSM GUARD→DRIVE; outputs still off.
  - Edge 2: digit 0 appears.
- Output latency is one cycle from the state/shadow change. A `load` captured at edge k is visible on `seg` at edge k+1 if the FSM is in DRIVE.
- `an` transitions from one digit to the next always pass through ≥1 all-off cycle. `an` never has two bits low.
- Reset mid-scan: scan restarts at digit 0 with `shadow`=0. Reset never produces a partial glitch.

## Configuration
- `HEX_DISPLAY_LZ_EN` defined: leading-zero suppression.
  - Digit i>0 is dark when nibbles i..DIGITS-1 of `shadow` are all zero.
  - Digit 0 is never suppressed.
  - A suppressed digit also hides its decimal point.
  - Darkness = OR of `blank_mask[i]` and suppression.
- `HEX_DISPLAY_LZ_EN` undefined: every digit not masked by `blank_mask` is shown, including leading zeros.

## Structure
- Package `hex_display_pkg`:
  - `SEG_OFF` = 7'b1111111.
  - The 16 segment constants.
  - FSM enum {GUARD, DRIVE}.
  - Function for counter width.
- Sub-module `hex_seg_lut`: combinational, 4-bit nibble → [0:6] active-low segments, using the package constants. One instance, fed by the nibble muxed by `idx`.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4.
1. Reset:
   - Hold `rst_n`=0 for 3 cycles → `an`=1111, `seg`=1111111, `dp_out`=1 throughout.
   - Release → first lit digit at edge 2 with `an`=1110, `seg`=0000001.
2. Scan order:
   - Load 16'h12AF → digit 0 `an`=1110 `seg`=0111000 for 4 cycles.
   - Then 1 all-off cycle.
   - Then `an`=1101 `seg`=0001000, `an`=1011 `seg`=0010010, `an`=0111 `seg`=1001111.
   - Wrap to digit 0 after 20 cycles.
3. Blanking and decimal points:
   - `blank_mask`=0100, `dp`=0001 → in the digit-2 slot, `an`=1111 and `seg`=1111111.
   - In the digit-0 slot, `dp_out`=0.
4. Mid-digit load:
   - While digit 0 shows 16'h0000, load 16'h0008 → `seg` changes 0000001→0000000 one cycle after the load edge.
   - `an` and slot length are unchanged.
5. Leading-zero suppression:
   - With `HEX_DISPLAY_LZ_EN`, value 16'h0005 → digits 1–3 keep `an`=1111; digit 0 shows 0100100.
   - Value 16'h0000 → digit 0 shows 0000001.
   - Without the macro, digits 1–3 show 0000001.
6. Reset mid-scan: drop `rst_n` during the digit-2 slot → outputs off asynchronously; after release, the scan restarts at digit 0 with `seg`=0000001.
